// File: rtl/rsa_modinv_seq_if.sv
// Handshake bundle for rsa_modinv_seq.
// The requester (master) drives start/e/phi; the engine (slave) returns
// busy/done/err/d and a debug view of its FSM state.
// With RSA_MODINV_CYCLES_EN defined, the bundle also carries the cycles count.
//
// Handshake: start is a request strobe sampled only while the engine is idle
// (busy=0 and done=0); e and phi are captured on that same edge. The
// operation ends with a one-cycle done pulse; err and d are valid from done
// and stay stable until the next accepted start.
interface rsa_modinv_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] phi;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] d;
    logic [1:0]       state;
`ifdef RSA_MODINV_CYCLES_EN
    logic [15:0]      cycles;
`endif

    modport master (
        output start, e, phi,
        input  busy, done, err, d, state
`ifdef RSA_MODINV_CYCLES_EN
        , input cycles
`endif
    );

    modport slave (
        input  start, e, phi,
        output busy, done, err, d, state
`ifdef RSA_MODINV_CYCLES_EN
        , output cycles
`endif
    );
endinterface

// File: rtl/rsa_modinv_seq.sv
// rsa_modinv_seq: sequential modular inverse d = e^-1 mod phi.
// First e is reduced modulo phi by repeated subtraction. Then candidates
// cnt = 1, 2, ... are walked, keeping acc == (cnt*e) mod phi with a single
// add/compare per cycle. No divider and no multiplier are used.
// Optional macro RSA_MODINV_CYCLES_EN adds a saturating cycles counter.
module rsa_modinv_seq #(
    parameter int WIDTH = 8
) (
    input logic              clk,
    input logic              rst_n,
    rsa_modinv_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REDUCE = 2'd1,
        S_SEARCH = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_e;
    logic [WIDTH-1:0] r_phi;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_d;
    logic             r_err;
    logic [WIDTH:0]   w_sum;
    logic             w_invalid;
    logic             w_busy;
    logic             w_done;

    // The extra sum bit keeps acc+e exact, so the compare against phi is exact.
    assign w_sum     = {1'b0, r_acc} + {1'b0, r_e};
    assign w_invalid = (bus.phi < WIDTH'(2)) || (bus.e == '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_next = w_invalid ? S_DONE : S_REDUCE;
            end
            S_REDUCE: begin
                if (r_e >= r_phi)    w_next = S_REDUCE;
                else if (r_e == '0)  w_next = S_DONE;
                else                 w_next = S_SEARCH;
            end
            S_SEARCH: begin
                if (r_acc == WIDTH'(1) || r_cnt == r_phi - WIDTH'(1)) w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Status outputs, decoded from the state alone.
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_REDUCE, S_SEARCH: w_busy = 1'b1;
            S_DONE:             w_done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand capture, reduction, candidate walk and result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e   <= '0;
            r_phi <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_d   <= '0;
            r_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_e   <= bus.e;
                        r_phi <= bus.phi;
                        r_d   <= '0;
                        r_err <= w_invalid;
                    end
                end
                S_REDUCE: begin
                    if (r_e >= r_phi) begin
                        r_e <= r_e - r_phi;
                    end else if (r_e == '0) begin
                        r_err <= 1'b1;
                    end else begin
                        r_acc <= r_e;
                        r_cnt <= WIDTH'(1);
                    end
                end
                S_SEARCH: begin
                    if (r_acc == WIDTH'(1)) begin
                        r_d <= r_cnt;
                    end else if (r_cnt == r_phi - WIDTH'(1)) begin
                        // Every candidate tried: gcd(e, phi) != 1.
                        r_err <= 1'b1;
                        r_d   <= '0;
                    end else begin
                        r_acc <= (w_sum >= {1'b0, r_phi}) ? WIDTH'(w_sum - {1'b0, r_phi})
                                                          : w_sum[WIDTH-1:0];
                        r_cnt <= r_cnt + WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef RSA_MODINV_CYCLES_EN
    logic [15:0] r_cycles;

    // Cycle count of the operation; saturates, then holds until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycles <= '0;
        end else if (r_state == S_IDLE && bus.start) begin
            r_cycles <= 16'd1;
        end else if ((r_state == S_REDUCE || r_state == S_SEARCH) && r_cycles != 16'hFFFF) begin
            r_cycles <= r_cycles + 16'd1;
        end
    end

    assign bus.cycles = r_cycles;
`endif

    assign bus.busy  = w_busy;
    assign bus.done  = w_done;
    assign bus.err   = r_err;
    assign bus.d     = r_d;
    assign bus.state = r_state;
endmodule

// File: tb/tb_rsa_modinv_seq.sv
// Testbench for rsa_modinv_seq: directed and random operations, with a
// scoreboard queue checked by a done-triggered monitor.
module tb_rsa_modinv_seq;
    localparam int W = 8;

    typedef struct {
        logic         err;
        logic [W-1:0] d;
        int           lat;
        int           s;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    rsa_modinv_seq_if #(.WIDTH(W)) bus();

    rsa_modinv_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: plain modular arithmetic plus the documented latency rules.
    function automatic exp_t model(input int e, input int phi, input int s);
        exp_t x;
        int   r;
        int   em;
        x.err = 1'b1;
        x.d   = '0;
        x.s   = s;
        if (phi < 2 || e == 0) begin
            x.lat = 1;
            return x;
        end
        r  = e / phi;
        em = e % phi;
        if (em == 0) begin
            x.lat = r + 2;
            return x;
        end
        x.lat = r + phi + 1;
        for (int k = 1; k < phi; k++) begin
            if ((k * em) % phi == 1) begin
                x.err = 1'b0;
                x.d   = W'(k);
                x.lat = r + k + 2;
                break;
            end
        end
        return x;
    endfunction

    // Wait (bounded) for the engine to be idle, observed on a falling edge.
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((bus.busy || bus.done) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("idle_timeout", n, 0);
    endtask

    // Issue one operation and push its expected result.
    task automatic start_op(input int e, input int phi);
        wait_idle();
        bus.start = 1'b1;
        bus.e     = W'(e);
        bus.phi   = W'(phi);
        @(posedge clk);
        #1;
        exp_q.push_back(model(e, phi, cyc));
        bus.start = 1'b0;
    endtask

    // Monitor: compare every done pulse against the oldest expectation.
    always @(negedge clk) begin
        exp_t x;
        if (rst_n && bus.done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                x = exp_q.pop_front();
                check("d", int'(bus.d), int'(x.d));
                check("err", int'(bus.err), int'(x.err));
                check("latency", cyc - x.s + 1, x.lat);
`ifdef RSA_MODINV_CYCLES_EN
                check("cycles", int'(bus.cycles), x.lat);
`endif
            end
        end
    end

    // Main stimulus sequence.
    initial begin
        int s1;
        int n;
        bus.start = 1'b0;
        bus.e     = '0;
        bus.phi   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_d", int'(bus.d), 0);
        check("rst_err", int'(bus.err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases from keygen-sized operands.
        start_op(5, 12);
        start_op(17, 12);
        start_op(4, 12);
        start_op(24, 12);
        start_op(3, 1);
        start_op(0, 12);
        start_op(3, 2);
        start_op(4, 2);

        // Start pulse while busy must be ignored.
        start_op(5, 12);
        @(negedge clk);
        bus.start = 1'b1;
        bus.e     = 8'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        start_op(7, 12);

        // Start held high: second operation accepted on first IDLE cycle after DONE.
        wait_idle();
        bus.start = 1'b1;
        bus.e     = 8'd5;
        bus.phi   = 8'd12;
        @(posedge clk);
        #1;
        s1 = cyc;
        exp_q.push_back(model(5, 12, s1));
        n = 0;
        @(negedge clk);
        while (!bus.done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("held_done_timeout", n, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        exp_q.push_back(model(5, 12, cyc));
        bus.start = 1'b0;

        // Reset in the middle of a search aborts with no done.
        start_op(5, 12);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_d", int'(bus.d), 0);
        check("abort_err", int'(bus.err), 0);
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        start_op(5, 12);

        // Random operands over the full 8-bit range.
        for (int i = 0; i < 40; i++) begin
            start_op($urandom_range(0, 255), $urandom_range(0, 255));
        end
        start_op($urandom_range(1, 255), $urandom_range(2, 20));

        // Drain outstanding expectations.
        n = 0;
        while ((exp_q.size() != 0 || bus.busy || bus.done) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("drain_timeout", exp_q.size(), 0);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
